// File: rtl/axis_fifo_pkt.sv
// AXI-stream FIFO with TLAST sideband, fill level, almost-full and first-word fall-through.
// Define AXIS_FIFO_PKT_MODE_EN to hold beats until a complete packet (or a full FIFO) is stored.
module axis_fifo_pkt #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 10,
  parameter int unsigned AF_THRESH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       up_valid,
  output logic                       up_ready,
  input  logic [WIDTH-1:0]           up_data,
  input  logic                       up_last,
  output logic                       down_valid,
  input  logic                       down_ready,
  output logic [WIDTH-1:0]           down_data,
  output logic                       down_last,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [WIDTH:0]  mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;
  logic            full, empty;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  assign up_ready    = ~full;
  assign push        = up_valid & up_ready;
  assign pop         = down_valid & down_ready;
  assign count       = count_q;
  assign almost_full = (count_q >= CntW'(AF_THRESH));
  assign down_data   = mem_q[rd_ptr_q][WIDTH-1:0];
  assign down_last   = mem_q[rd_ptr_q][WIDTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; empty/packet gating keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {up_last, up_data};
    end
  end

`ifdef AXIS_FIFO_PKT_MODE_EN
  logic [CntW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic            dv_hold_q, dv_hold_d;
  logic            push_last, pop_last;

  assign push_last = push & up_last;
  assign pop_last  = pop & down_last;

  // Full with no complete packet releases beats cut-through so long packets cannot deadlock.
  assign down_valid = ~empty & ((pkt_cnt_q != '0) | full | dv_hold_q);

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    case ({push_last, pop_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
      2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    dv_hold_d = down_valid & ~down_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt_q <= '0;
      dv_hold_q <= 1'b0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      dv_hold_q <= dv_hold_d;
    end
  end
`else
  assign down_valid = ~empty;
`endif

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// Scoreboard bench for axis_fifo_pkt (WIDTH=8, DEPTH=4, AF_THRESH=3).
// Packet-mode scenarios run only when AXIS_FIFO_PKT_MODE_EN is defined.
module tb_axis_fifo_pkt;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid, up_ready, up_last;
  logic [7:0] up_data;
  logic       down_valid, down_ready, down_last;
  logic [7:0] down_data;
  logic [2:0] count;
  logic       almost_full;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] sb [$];
  logic [8:0] exp_beat;
  logic       push_fire, pop_fire, pop_last_s;
  logic [7:0] pop_data_s;

  always #5 clk = ~clk;

  axis_fifo_pkt #(
    .WIDTH     (8),
    .DEPTH     (4),
    .AF_THRESH (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .up_valid    (up_valid),
    .up_ready    (up_ready),
    .up_data     (up_data),
    .up_last     (up_last),
    .down_valid  (down_valid),
    .down_ready  (down_ready),
    .down_data   (down_data),
    .down_last   (down_last),
    .count       (count),
    .almost_full (almost_full)
  );

  // Sample handshakes on the falling edge, then advance to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    push_fire  = up_valid && up_ready;
    pop_fire   = down_valid && down_ready;
    pop_data_s = down_data;
    pop_last_s = down_last;
    if (push_fire) sb.push_back({up_last, up_data});
    @(posedge clk);
    #1;
  endtask

  task automatic check_pop(input string name);
    // records a popped beat against the scoreboard head
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got unexpected pop %h, scoreboard empty", name, pop_data_s);
    end else begin
      exp_beat = sb.pop_front();
      if ({pop_last_s, pop_data_s} !== exp_beat) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", name, {pop_last_s, pop_data_s}, exp_beat);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; up_valid = 1'b0; up_data = '0; up_last = 1'b0; down_ready = 1'b0;
    #2;
    n_checks++;
    if (up_ready !== 1'b1 || down_valid !== 1'b0 || count !== 3'd0 || almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b cnt=%0d af=%b want 1 0 0 0",
               up_ready, down_valid, count, almost_full);
    end
    #10 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    down_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up_valid = 1'b1; up_data = 8'(8'h11 * (i + 1)); up_last = (i == 3);
      step();
      n_checks++;
      if (push_fire !== 1'b1 || count !== 3'(i + 1)) begin
        n_fail++;
        $display("FAIL fill_count%0d: got push=%b cnt=%0d want 1 %0d", i, push_fire, count, i + 1);
      end
      n_checks++;
      if (almost_full !== (i + 1 >= 3) || up_ready !== (i < 3)) begin
        n_fail++;
        $display("FAIL fill_flags%0d: got af=%b rdy=%b want %b %b", i, almost_full, up_ready,
                 (i + 1 >= 3), (i < 3));
      end
`ifdef AXIS_FIFO_PKT_MODE_EN
      n_checks++;
      if (down_valid !== (i == 3)) begin
        n_fail++;
        $display("FAIL fill_valid%0d: got %b want %b", i, down_valid, (i == 3));
      end
`else
      n_checks++;
      if (down_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_valid%0d: got %b want 1", i, down_valid);
      end
`endif
    end
    up_data = 8'h55; up_last = 1'b1;
    step();
    n_checks++;
    if (push_fire !== 1'b0 || count !== 3'd4 || up_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_hold: got push=%b cnt=%0d rdy=%b want 0 4 0", push_fire, count, up_ready);
    end
  endtask

  task automatic test_drain_wrap();
    int pops = 0;
    int push_cyc = -1;
    down_ready = 1'b1;
    for (int c = 0; c < 20 && pops < 5; c++) begin
      step();
      if (push_fire) begin
        push_cyc = c;
        up_valid = 1'b0;
      end
      if (pop_fire) begin
        check_pop("drain_data");
        pops++;
      end
    end
    n_checks++;
    if (pops != 5 || push_cyc != 1) begin
      n_fail++;
      $display("FAIL drain_order: got pops=%0d push_cycle=%0d want 5 1", pops, push_cyc);
    end
    n_checks++;
    if (count !== 3'd0 || down_valid !== 1'b0 || up_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: got cnt=%0d vld=%b rdy=%b want 0 0 1", count, down_valid, up_ready);
    end
  endtask

  task automatic test_back_to_back();
    int pops = 0;
    down_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      up_valid = 1'b1; up_data = 8'(8'h60 + i); up_last = 1'b1;
      step();
    end
    down_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      up_data = 8'(8'h62 + k); up_last = k[0];
      step();
      n_checks++;
      if (push_fire !== 1'b1 || pop_fire !== 1'b1 || count !== 3'd2) begin
        n_fail++;
        $display("FAIL b2b_flow%0d: got push=%b pop=%b cnt=%0d want 1 1 2", k, push_fire, pop_fire,
                 count);
      end
      if (pop_fire) check_pop("b2b_data");
    end
    up_valid = 1'b0;
    for (int c = 0; c < 10 && pops < 2; c++) begin
      step();
      if (pop_fire) begin
        check_pop("b2b_tail");
        pops++;
      end
    end
    n_checks++;
    if (pops != 2 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_drain: got pops=%0d cnt=%0d want 2 0", pops, count);
    end
  endtask

  task automatic test_async_reset();
    int pops = 0;
    down_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      up_valid = 1'b1; up_data = 8'(8'h70 + i); up_last = 1'b1;
      step();
    end
    n_checks++;
    if (count !== 3'd3) begin
      n_fail++;
      $display("FAIL arst_pre: got cnt=%0d want 3", count);
    end
    up_data = 8'h73;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (down_valid !== 1'b0 || count !== 3'd0 || up_ready !== 1'b1 || almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_now: got vld=%b cnt=%0d rdy=%b af=%b want 0 0 1 0", down_valid, count,
               up_ready, almost_full);
    end
    sb.delete();
    up_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    down_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (down_valid !== 1'b0 || pop_fire !== 1'b0 || count !== 3'd0) begin
        n_fail++;
        $display("FAIL arst_stale%0d: got vld=%b pop=%b cnt=%0d want 0 0 0", c, down_valid,
                 pop_fire, count);
      end
    end
    up_valid = 1'b1; up_data = 8'h5A; up_last = 1'b1;
    step();
    up_valid = 1'b0;
    for (int c = 0; c < 5 && pops < 1; c++) begin
      step();
      if (pop_fire) begin
        check_pop("arst_fresh");
        pops++;
      end
    end
    n_checks++;
    if (pops != 1) begin
      n_fail++;
      $display("FAIL arst_fresh_cnt: got pops=%0d want 1", pops);
    end
  endtask

`ifdef AXIS_FIFO_PKT_MODE_EN
  task automatic test_pkt_gate();
    int pops = 0;
    down_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up_valid = 1'b1; up_data = 8'(8'hA0 + i); up_last = (i == 2);
      step();
      n_checks++;
      if (down_valid !== (i == 2) || count !== 3'(i + 1)) begin
        n_fail++;
        $display("FAIL pkt_gate%0d: got vld=%b cnt=%0d want %b %0d", i, down_valid, count,
                 (i == 2), i + 1);
      end
    end
    up_valid = 1'b0;
    for (int c = 0; c < 10 && pops < 3; c++) begin
      step();
      if (pop_fire) begin
        check_pop("pkt_data");
        pops++;
        n_checks++;
        if (pop_last_s !== (pops == 3)) begin
          n_fail++;
          $display("FAIL pkt_last%0d: got %b want %b", pops, pop_last_s, (pops == 3));
        end
      end
    end
    n_checks++;
    if (pops != 3 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL pkt_drain: got pops=%0d cnt=%0d want 3 0", pops, count);
    end
  endtask

  task automatic test_pkt_override();
    int pops = 0;
    down_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up_valid = 1'b1; up_data = 8'(8'hB0 + i); up_last = 1'b0;
      step();
    end
    n_checks++;
    if (count !== 3'd4 || down_valid !== 1'b1 || up_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_full: got cnt=%0d vld=%b rdy=%b want 4 1 0", count, down_valid, up_ready);
    end
    up_data = 8'hB4; up_last = 1'b1; down_ready = 1'b1;
    for (int c = 0; c < 40 && pops < 5; c++) begin
      step();
      if (push_fire) up_valid = 1'b0;
      if (pop_fire) begin
        check_pop("ovr_data");
        pops++;
      end
    end
    n_checks++;
    if (pops != 5 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL ovr_drain: got pops=%0d cnt=%0d want 5 0", pops, count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_drain_wrap();
    test_back_to_back();
    test_async_reset();
`ifdef AXIS_FIFO_PKT_MODE_EN
    test_pkt_gate();
    test_pkt_override();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
